// File: rtl/reservation_alu3_issue.sv
// ALU3 reservation read side: picks the lowest-index ready entry, retires it with a
// zero-latency one-hot pulse and captures its operands into a registered issue stage.
module reservation_alu3_issue #(
  parameter int ENTRY_NUM = 4,
  parameter int PTR_W     = 4
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET,
  input  logic                   iFLUSH,
  input  logic [ENTRY_NUM-1:0]   iENTRY_VALID,
  input  logic [ENTRY_NUM-1:0]   iENTRY_MATCHING,
  input  logic [5*ENTRY_NUM-1:0] iENTRY_CMD,
  input  logic [ENTRY_NUM-1:0]   iENTRY_SYS_LDST,
  input  logic [ENTRY_NUM-1:0]   iENTRY_LDST,
  input  logic [ENTRY_NUM-1:0]   iENTRY_ADV_ACTIVE,
  input  logic [ENTRY_NUM-1:0]   iENTRY_DESTINATION_SYSREG,
  input  logic [32*ENTRY_NUM-1:0] iENTRY_SOURCE0,
  input  logic [32*ENTRY_NUM-1:0] iENTRY_SOURCE1,
  input  logic [32*ENTRY_NUM-1:0] iENTRY_PC,
  input  logic [6*ENTRY_NUM-1:0] iENTRY_ADV_DATA,
  input  logic [6*ENTRY_NUM-1:0] iENTRY_DESTINATION_REGNAME,
  input  logic [6*ENTRY_NUM-1:0] iENTRY_COMMIT_TAG,
  output logic [ENTRY_NUM-1:0]   oEXOUT_VALID,
  output logic [PTR_W-1:0]       oEX_EXECUTION_POINTER,
  input  logic                   iALU_LOCK,
  output logic                   oALU_VALID,
  output logic [4:0]             oALU_CMD,
  output logic                   oALU_SYS_LDST,
  output logic                   oALU_LDST,
  output logic [31:0]            oALU_SOURCE0,
  output logic [31:0]            oALU_SOURCE1,
  output logic                   oALU_ADV_ACTIVE,
  output logic [5:0]             oALU_ADV_DATA,
  output logic [5:0]             oALU_DESTINATION_REGNAME,
  output logic                   oALU_DESTINATION_SYSREG,
  output logic [5:0]             oALU_COMMIT_TAG,
  output logic [31:0]            oALU_PC
);

  logic [ENTRY_NUM-1:0] cand, sel;
  logic can_accept, issue;
  logic [4:0]  sel_cmd;
  logic        sel_sys_ldst, sel_ldst, sel_adv_active, sel_dest_sysreg;
  logic [31:0] sel_source0, sel_source1, sel_pc;
  logic [5:0]  sel_adv_data, sel_dest_regname, sel_commit_tag;

  // Selection stage: lowest set bit of the candidate vector wins.
  assign cand       = iENTRY_VALID & iENTRY_MATCHING;
  assign sel        = cand & (~cand + ENTRY_NUM'(1));
  assign can_accept = !oALU_VALID || !iALU_LOCK;
  assign issue      = (|cand) && can_accept && !iFLUSH && !iRESET;
  assign oEXOUT_VALID = issue ? sel : '0;

  // One-hot OR mux of the selected entry's fields.
  always_comb begin
    sel_cmd          = '0;
    sel_sys_ldst     = 1'b0;
    sel_ldst         = 1'b0;
    sel_adv_active   = 1'b0;
    sel_dest_sysreg  = 1'b0;
    sel_source0      = '0;
    sel_source1      = '0;
    sel_pc           = '0;
    sel_adv_data     = '0;
    sel_dest_regname = '0;
    sel_commit_tag   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (sel[i]) begin
        sel_cmd          = iENTRY_CMD[i*5 +: 5];
        sel_sys_ldst     = iENTRY_SYS_LDST[i];
        sel_ldst         = iENTRY_LDST[i];
        sel_adv_active   = iENTRY_ADV_ACTIVE[i];
        sel_dest_sysreg  = iENTRY_DESTINATION_SYSREG[i];
        sel_source0      = iENTRY_SOURCE0[i*32 +: 32];
        sel_source1      = iENTRY_SOURCE1[i*32 +: 32];
        sel_pc           = iENTRY_PC[i*32 +: 32];
        sel_adv_data     = iENTRY_ADV_DATA[i*6 +: 6];
        sel_dest_regname = iENTRY_DESTINATION_REGNAME[i*6 +: 6];
        sel_commit_tag   = iENTRY_COMMIT_TAG[i*6 +: 6];
      end
    end
  end

  // Issue register stage: flush beats issue, issue beats drain; payload held otherwise.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET || iFLUSH) begin
      oALU_VALID               <= 1'b0;
      oEX_EXECUTION_POINTER    <= '0;
      oALU_CMD                 <= '0;
      oALU_SYS_LDST            <= 1'b0;
      oALU_LDST                <= 1'b0;
      oALU_SOURCE0             <= '0;
      oALU_SOURCE1             <= '0;
      oALU_ADV_ACTIVE          <= 1'b0;
      oALU_ADV_DATA            <= '0;
      oALU_DESTINATION_REGNAME <= '0;
      oALU_DESTINATION_SYSREG  <= 1'b0;
      oALU_COMMIT_TAG          <= '0;
      oALU_PC                  <= '0;
    end else if (issue) begin
      oALU_VALID               <= 1'b1;
      oEX_EXECUTION_POINTER    <= oEX_EXECUTION_POINTER + PTR_W'(1);
      oALU_CMD                 <= sel_cmd;
      oALU_SYS_LDST            <= sel_sys_ldst;
      oALU_LDST                <= sel_ldst;
      oALU_SOURCE0             <= sel_source0;
      oALU_SOURCE1             <= sel_source1;
      oALU_ADV_ACTIVE          <= sel_adv_active;
      oALU_ADV_DATA            <= sel_adv_data;
      oALU_DESTINATION_REGNAME <= sel_dest_regname;
      oALU_DESTINATION_SYSREG  <= sel_dest_sysreg;
      oALU_COMMIT_TAG          <= sel_commit_tag;
      oALU_PC                  <= sel_pc;
    end else if (oALU_VALID && !iALU_LOCK) begin
      oALU_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_alu3_issue.sv
// Directed bench for reservation_alu3_issue: selection, retire pulse, lock, flush and wrap.
module tb_reservation_alu3_issue;
  localparam int N = 4;

  logic clk, rst, flush, lock;
  logic [N-1:0]    ev, em, sys_ldst, ldst, adv_act, dsys;
  logic [5*N-1:0]  cmd;
  logic [32*N-1:0] s0, s1, pc;
  logic [6*N-1:0]  advd, rn, tag;
  logic [N-1:0]    exout;
  logic [3:0]      ptr;
  logic            a_valid, a_sys_ldst, a_ldst, a_adv_act, a_dsys;
  logic [4:0]      a_cmd;
  logic [31:0]     a_s0, a_s1, a_pc;
  logic [5:0]      a_advd, a_rn, a_tag;

  int checks = 0;
  int errors = 0;

  reservation_alu3_issue #(.ENTRY_NUM(N), .PTR_W(4)) dut (
    .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush),
    .iENTRY_VALID(ev), .iENTRY_MATCHING(em), .iENTRY_CMD(cmd),
    .iENTRY_SYS_LDST(sys_ldst), .iENTRY_LDST(ldst), .iENTRY_ADV_ACTIVE(adv_act),
    .iENTRY_DESTINATION_SYSREG(dsys), .iENTRY_SOURCE0(s0), .iENTRY_SOURCE1(s1),
    .iENTRY_PC(pc), .iENTRY_ADV_DATA(advd), .iENTRY_DESTINATION_REGNAME(rn),
    .iENTRY_COMMIT_TAG(tag), .oEXOUT_VALID(exout), .oEX_EXECUTION_POINTER(ptr),
    .iALU_LOCK(lock), .oALU_VALID(a_valid), .oALU_CMD(a_cmd),
    .oALU_SYS_LDST(a_sys_ldst), .oALU_LDST(a_ldst), .oALU_SOURCE0(a_s0),
    .oALU_SOURCE1(a_s1), .oALU_ADV_ACTIVE(a_adv_act), .oALU_ADV_DATA(a_advd),
    .oALU_DESTINATION_REGNAME(a_rn), .oALU_DESTINATION_SYSREG(a_dsys),
    .oALU_COMMIT_TAG(a_tag), .oALU_PC(a_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry i gets SOURCE1 = ~SOURCE0, REGNAME = i+1, COMMIT_TAG = i+8, ADV_DATA = i+16, LDST = 1.
  task automatic set_entry(input int i, input logic [4:0] c, input logic [31:0] a, input logic [31:0] p);
    ev[i] = 1'b1; em[i] = 1'b1;
    cmd[i*5 +: 5] = c; s0[i*32 +: 32] = a; s1[i*32 +: 32] = ~a; pc[i*32 +: 32] = p;
    rn[i*6 +: 6] = 6'(i + 1); tag[i*6 +: 6] = 6'(i + 8); advd[i*6 +: 6] = 6'(i + 16);
    ldst[i] = 1'b1; sys_ldst[i] = 1'b0; adv_act[i] = 1'b1; dsys[i] = 1'b0;
  endtask

  task automatic clr_entry(input int i);
    ev[i] = 1'b0; em[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; lock = 1'b0;
    ev = '0; em = '0; sys_ldst = '0; ldst = '0; adv_act = '0; dsys = '0;
    cmd = '0; s0 = '0; s1 = '0; pc = '0; advd = '0; rn = '0; tag = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; lock = 1'b0;
    ev = '0; em = '0; sys_ldst = '0; ldst = '0; adv_act = '0; dsys = '0;
    cmd = '0; s0 = '0; s1 = '0; pc = '0; advd = '0; rn = '0; tag = '0;
    set_entry(0, 5'h1F, 32'hDEAD_BEEF, 32'h10);
    step(); #1;
    checks++; if (exout !== 4'b0000) begin errors++; $display("FAIL reset_exout: got %b expected %b", exout, 4'b0000); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
    checks++; if (a_cmd !== 5'd0 || a_s0 !== 32'd0 || a_pc !== 32'd0) begin errors++; $display("FAIL reset_payload: got cmd=%h s0=%h pc=%h expected zeros", a_cmd, a_s0, a_pc); end
    clr_entry(0);
    rst = 1'b0;
    step(); step();
    checks++; if (a_valid !== 1'b0 || ptr !== 4'd0) begin errors++; $display("FAIL idle: got valid=%b ptr=%0d expected 0/0", a_valid, ptr); end
  endtask

  task automatic test_single_issue();
    do_reset();
    lock = 1'b1; // lock while the register is empty must not block
    set_entry(2, 5'h0A, 32'h1234_5678, 32'h0000_0100);
    #1;
    checks++; if (exout !== 4'b0100) begin errors++; $display("FAIL single_exout: got %b expected %b", exout, 4'b0100); end
    step(); clr_entry(2); lock = 1'b0; #1;
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", a_valid); end
    checks++; if (a_cmd !== 5'h0A) begin errors++; $display("FAIL single_cmd: got %h expected 0a", a_cmd); end
    checks++; if (a_s0 !== 32'h1234_5678 || a_s1 !== 32'hEDCB_A987) begin errors++; $display("FAIL single_src: got %h/%h expected 12345678/edcba987", a_s0, a_s1); end
    checks++; if (a_pc !== 32'h0000_0100) begin errors++; $display("FAIL single_pc: got %h expected 00000100", a_pc); end
    checks++; if (a_rn !== 6'd3 || a_tag !== 6'd10 || a_advd !== 6'd18) begin errors++; $display("FAIL single_tags: got rn=%0d tag=%0d adv=%0d expected 3/10/18", a_rn, a_tag, a_advd); end
    checks++; if (a_ldst !== 1'b1 || a_adv_act !== 1'b1 || a_sys_ldst !== 1'b0 || a_dsys !== 1'b0) begin errors++; $display("FAIL single_flags: got %b%b%b%b expected 1100", a_ldst, a_adv_act, a_sys_ldst, a_dsys); end
    checks++; if (ptr !== 4'd1) begin errors++; $display("FAIL single_ptr: got %0d expected 1", ptr); end
    checks++; if (exout !== 4'b0000) begin errors++; $display("FAIL single_no_cand: got %b expected 0000", exout); end
    step();
    checks++; if (a_valid !== 1'b0 || a_cmd !== 5'h0A || ptr !== 4'd1) begin errors++; $display("FAIL single_drain: got valid=%b cmd=%h ptr=%0d expected 0/0a/1", a_valid, a_cmd, ptr); end
  endtask

  task automatic test_priority();
    do_reset();
    set_entry(1, 5'h01, 32'h1111_1111, 32'h200);
    set_entry(3, 5'h03, 32'h3333_3333, 32'h300);
    #1;
    checks++; if (exout !== 4'b0010) begin errors++; $display("FAIL prio_exout: got %b expected 0010", exout); end
    step(); clr_entry(1); #1;
    checks++; if (a_valid !== 1'b1 || a_cmd !== 5'h01 || a_pc !== 32'h200) begin errors++; $display("FAIL prio_first: got valid=%b cmd=%h pc=%h expected 1/01/200", a_valid, a_cmd, a_pc); end
    checks++; if (exout !== 4'b1000) begin errors++; $display("FAIL prio_second_exout: got %b expected 1000", exout); end
    step(); clr_entry(3); #1;
    checks++; if (a_valid !== 1'b1 || a_cmd !== 5'h03 || a_s0 !== 32'h3333_3333) begin errors++; $display("FAIL prio_second: got valid=%b cmd=%h s0=%h expected 1/03/33333333", a_valid, a_cmd, a_s0); end
    checks++; if (ptr !== 4'd2) begin errors++; $display("FAIL prio_ptr: got %0d expected 2", ptr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_entry(2, 5'h03, 32'hAAAA_0000, 32'h400);
    step(); clr_entry(2);
    lock = 1'b1;
    set_entry(0, 5'h11, 32'hBBBB_0000, 32'h500);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (exout !== 4'b0000) begin errors++; $display("FAIL bp_exout[%0d]: got %b expected 0000", k, exout); end
      checks++; if (a_valid !== 1'b1 || a_cmd !== 5'h03 || a_s0 !== 32'hAAAA_0000) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b cmd=%h s0=%h expected 1/03/aaaa0000", k, a_valid, a_cmd, a_s0); end
      step();
    end
    checks++; if (ptr !== 4'd1) begin errors++; $display("FAIL bp_ptr_hold: got %0d expected 1", ptr); end
    lock = 1'b0; #1;
    checks++; if (exout !== 4'b0001) begin errors++; $display("FAIL bp_release_exout: got %b expected 0001", exout); end
    step(); clr_entry(0); #1;
    checks++; if (a_valid !== 1'b1 || a_cmd !== 5'h11 || a_pc !== 32'h500) begin errors++; $display("FAIL bp_new: got valid=%b cmd=%h pc=%h expected 1/11/500", a_valid, a_cmd, a_pc); end
    checks++; if (ptr !== 4'd2) begin errors++; $display("FAIL bp_ptr: got %0d expected 2", ptr); end
  endtask

  task automatic test_flush();
    do_reset();
    set_entry(0, 5'h05, 32'h5555_5555, 32'h600);
    for (int k = 0; k < 9; k++) step();
    clr_entry(0); #1;
    checks++; if (ptr !== 4'd9 || a_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: got ptr=%0d valid=%b expected 9/1", ptr, a_valid); end
    flush = 1'b1;
    set_entry(1, 5'h07, 32'h7777_7777, 32'h700);
    #1;
    checks++; if (exout !== 4'b0000) begin errors++; $display("FAIL flush_exout: got %b expected 0000", exout); end
    step(); flush = 1'b0; clr_entry(1); #1;
    checks++; if (a_valid !== 1'b0 || ptr !== 4'd0) begin errors++; $display("FAIL flush_state: got valid=%b ptr=%0d expected 0/0", a_valid, ptr); end
    checks++; if (a_cmd !== 5'd0 || a_s0 !== 32'd0 || a_pc !== 32'd0) begin errors++; $display("FAIL flush_payload: got cmd=%h s0=%h pc=%h expected zeros", a_cmd, a_s0, a_pc); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_ptr;
    do_reset();
    set_entry(0, 5'h09, 32'h0000_0009, 32'h900);
    exp_ptr = 4'd0;
    for (int k = 0; k < 17; k++) begin
      #1;
      checks++; if (ptr !== exp_ptr || exout !== 4'b0001) begin errors++; $display("FAIL wrap[%0d]: got ptr=%0d exout=%b expected %0d/0001", k, ptr, exout, exp_ptr); end
      exp_ptr = exp_ptr + 4'd1;
      step();
    end
    clr_entry(0); #1;
    checks++; if (ptr !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d expected 1", ptr); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_entry(0, 5'h0C, 32'hCCCC_CCCC, 32'hC00);
    for (int k = 0; k < 5; k++) step();
    lock = 1'b1; #1;
    checks++; if (ptr !== 4'd5 || a_valid !== 1'b1 || a_cmd !== 5'h0C) begin errors++; $display("FAIL midrst_setup: got ptr=%0d valid=%b cmd=%h expected 5/1/0c", ptr, a_valid, a_cmd); end
    lock = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (a_valid !== 1'b0 || ptr !== 4'd0) begin errors++; $display("FAIL midrst_state: got valid=%b ptr=%0d expected 0/0", a_valid, ptr); end
    checks++; if (a_cmd !== 5'd0 || a_s0 !== 32'd0 || a_pc !== 32'd0 || a_tag !== 6'd0) begin errors++; $display("FAIL midrst_payload: got cmd=%h s0=%h pc=%h tag=%h expected zeros", a_cmd, a_s0, a_pc, a_tag); end
    checks++; if (exout !== 4'b0000) begin errors++; $display("FAIL midrst_exout: got %b expected 0000", exout); end
    step(); clr_entry(0); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_priority();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_alu3_issue.md
Name: reservation_alu3_issue

Overview:
- Read side of the ALU3 reservation entries.
- Each cycle it scans the INFO outputs of ENTRY_NUM entries and selects one ready (matching) entry.
- It pulses that entry's EXOUT_VALID to retire it and captures its operands into a registered issue stage toward the ALU3 execution unit.
- It owns the in-order EX execution pointer that the entries compare against.

Parameters:
- ENTRY_NUM, 4, number of reservation entries scanned; flattened bus index i holds entry i.
- PTR_W, 4, width of the EX execution pointer; wraps modulo 2^PTR_W.

Ports:
- iCLOCK  in  1  clock, rising edge.
- iRESET  in  1  asynchronous reset, active-high.
- iFLUSH  in  1  synchronous pipeline flush; same event that drives the entries' REMOVE_VALID.
- iENTRY_VALID  in  ENTRY_NUM  per-entry occupied flag.
- iENTRY_MATCHING  in  ENTRY_NUM  per-entry ready flag: sources valid and pointer matched.
- iENTRY_CMD  in  5*ENTRY_NUM  command.
- iENTRY_SYS_LDST, iENTRY_LDST, iENTRY_ADV_ACTIVE, iENTRY_DESTINATION_SYSREG  in  ENTRY_NUM each  flags.
- iENTRY_SOURCE0, iENTRY_SOURCE1, iENTRY_PC  in  32*ENTRY_NUM each  operands / PC.
- iENTRY_ADV_DATA, iENTRY_DESTINATION_REGNAME, iENTRY_COMMIT_TAG  in  6*ENTRY_NUM each.
- oEXOUT_VALID  out  ENTRY_NUM  one-hot retire pulse to the selected entry; combinational.
- oEX_EXECUTION_POINTER  out  PTR_W  registered in-order pointer.
- iALU_LOCK  in  1  execution unit cannot accept; holds the issue register.
- oALU_VALID  out  1  issue register holds a valid instruction.
- oALU_CMD 5, oALU_SYS_LDST 1, oALU_LDST 1, oALU_SOURCE0 32, oALU_SOURCE1 32, oALU_ADV_ACTIVE 1, oALU_ADV_DATA 6, oALU_DESTINATION_REGNAME 6, oALU_DESTINATION_SYSREG 1, oALU_COMMIT_TAG 6, oALU_PC 32  out  registered issue payload.

Behaviour:
- Reset (iRESET high, async):
  - oALU_VALID=0, all oALU_* payload=0, oEX_EXECUTION_POINTER=0.
  - oEXOUT_VALID is forced to 0 while iRESET is high.
- Candidate set: cand[i] = iENTRY_VALID[i] & iENTRY_MATCHING[i].
- Selection: fixed priority, lowest index wins. sel is a one-hot of the lowest set bit of cand.
- can_accept = !oALU_VALID | !iALU_LOCK. The issue register is empty, or is being consumed this cycle.
- issue = |cand & can_accept & !iFLUSH & !iRESET.
- oEXOUT_VALID = issue ? sel : 0, in the same cycle as the selection, with zero latency. The entry clears at the following edge.
- Issue register update, priority highest first:
  1. iFLUSH: oALU_VALID<=0, payload<=0, pointer<=0. Flush overrides issue and lock.
  2. issue: oALU_VALID<=1, payload<=selected entry's fields, pointer<=pointer+1 (wraps 2^PTR_W-1 -> 0).
  3. oALU_VALID & !iALU_LOCK (consumed, nothing new): oALU_VALID<=0. Payload holds its last value.
  4. Otherwise hold all registers; the payload is stable while oALU_VALID & iALU_LOCK.
- Issue-to-ALU latency: 1 cycle (oALU_VALID rises on the edge after oEXOUT_VALID pulses).
- Throughput: at most one issue per cycle. Back-to-back issue needs the next entry's MATCHING, which depends on the updated pointer, so sustained rate is set by entry timing.
- No candidates: no pulse, pointer unchanged.
- Multiple candidates: only the lowest index is pulsed; the others stay and compete next cycle.
- A candidate present while the register is full and locked: no pulse; the entry is untouched.
- iALU_LOCK while oALU_VALID=0 has no effect; issue proceeds.
- Entry fields are sampled only on the issue edge. Later changes to an entry never alter the issue register.

Test Plan:
- Reset then idle. Assert iRESET mid-operation with oALU_VALID=1 and pointer=5 -> immediately oALU_VALID=0, payload=0, pointer=0, oEXOUT_VALID=0.
- Single issue. Entry 2 valid+matching, CMD=5'h0A, SOURCE0=32'h1234_5678, PC=32'h0000_0100 -> same cycle oEXOUT_VALID=4'b0100; next cycle oALU_VALID=1 with those fields, pointer 0->1.
- Priority. Entries 1 and 3 both ready -> oEXOUT_VALID=4'b0010. Entry 3 is pulsed on a later cycle once the register is free; pointer advances by 2 total.
- Backpressure. oALU_VALID=1, iALU_LOCK=1 for 3 cycles with entry 0 ready -> oEXOUT_VALID=0 and payload constant. Lock drops -> same cycle pulse 4'b0001; next cycle new payload, no cycle with oALU_VALID=0.
- Flush collision. iFLUSH=1 with entry 1 ready and pointer=9 -> oEXOUT_VALID=0; next cycle oALU_VALID=0 and pointer=0.
- Wrap. Issue 17 instructions from reset -> pointer sequence 0..15, 0, 1; final value 1.
